// File: rtl/gs_residual_pkg.sv
// Shared constants, state encoding and binary32 arithmetic primitives for the residual unit.
// The adder and multiplier round to nearest-even.
package gs_residual_pkg;

   localparam int FP_W      = 32;
   localparam int VEC_W     = 128;
   localparam int NUM_LANES = 4;

   localparam int LANE0_HI = 127;
   localparam int LANE0_LO = 96;
   localparam int LANE1_HI = 95;
   localparam int LANE1_LO = 64;
   localparam int LANE2_HI = 63;
   localparam int LANE2_LO = 32;
   localparam int LANE3_HI = 31;
   localparam int LANE3_LO = 0;

   localparam int LANE_HI [NUM_LANES] = '{LANE0_HI, LANE1_HI, LANE2_HI, LANE3_HI};
   localparam int LANE_LO [NUM_LANES] = '{LANE0_LO, LANE1_LO, LANE2_LO, LANE3_LO};

   localparam int SIGN_BIT = 31;
   localparam int EXP_HI   = 30;
   localparam int EXP_LO   = 23;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SUB  = 3'd1;
   localparam logic [2:0] ST_SQR  = 3'd2;
   localparam logic [2:0] ST_ADD1 = 3'd3;
   localparam logic [2:0] ST_ADD2 = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      SUB  = ST_SUB,
      SQR  = ST_SQR,
      ADD1 = ST_ADD1,
      ADD2 = ST_ADD2
   } state_t;

   // Guard/round/sticky adder; denormals handled, equal-magnitude cancellation gives +0.
   function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] a;
      logic [31:0] b;
      logic [26:0] ma;
      logic [26:0] mb;
      logic [49:0] mbw;
      logic [27:0] r;
      logic [24:0] m;
      logic        found;
      logic        inc;
      int          ea;
      int          eb;
      int          d;
      int          e;
      int          lz;
      if (x[30:0] >= y[30:0]) begin
         a = x;
         b = y;
      end else begin
         a = y;
         b = x;
      end
      if (a[30:23] == 8'hFF) begin
         if (b[30:23] == 8'hFF && a[31] != b[31]) return 32'h7FC0_0000;
         return a;
      end
      ea  = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
      eb  = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
      d   = ea - eb;
      if (d > 26) d = 26;
      ma  = {a[30:23] != 8'd0, a[22:0], 3'b000};
      mbw = {b[30:23] != 8'd0, b[22:0], 26'd0} >> d;
      mb  = {mbw[49:24], |mbw[23:0]};
      if (a[31] == b[31]) r = {1'b0, ma} + {1'b0, mb};
      else                r = {1'b0, ma} - {1'b0, mb};
      if (r == 28'd0) return (a[31] == b[31]) ? {a[31], 31'd0} : 32'd0;
      e = ea;
      if (r[27]) begin
         r = {1'b0, r[27:2], r[1] | r[0]};
         e = e + 1;
      end else begin
         lz    = 0;
         found = 1'b0;
         for (int k = 26; k >= 0; k--) begin
            if (!found) begin
               if (r[k]) found = 1'b1;
               else      lz = lz + 1;
            end
         end
         if (lz > e - 1) lz = e - 1;
         r = r << lz;
         e = e - lz;
      end
      inc = r[2] & (r[1] | r[0] | r[3]);
      m   = {1'b0, r[26:3]} + {24'd0, inc};
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= 255) return {a[31], 8'hFF, 23'd0};
      return {a[31], m[23] ? e[7:0] : 8'd0, m[22:0]};
   endfunction

   // Denormal inputs and underflowing products flush to signed zero.
   function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
      logic        s;
      logic [47:0] p;
      logic [23:0] mt;
      logic        g;
      logic        st;
      logic [24:0] m;
      int          e;
      s = x[31] ^ y[31];
      if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0))
         return 32'h7FC0_0000;
      if (x[30:23] == 8'hFF || y[30:23] == 8'hFF)
         return (x[30:23] == 8'd0 || y[30:23] == 8'd0) ? 32'h7FC0_0000 : {s, 8'hFF, 23'd0};
      if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
      p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
      e = int'(x[30:23]) + int'(y[30:23]) - 127;
      if (p[47]) begin
         mt = p[47:24];
         g  = p[23];
         st = |p[22:0];
         e  = e + 1;
      end else begin
         mt = p[46:23];
         g  = p[22];
         st = |p[21:0];
      end
      m = {1'b0, mt} + {24'd0, g & (st | mt[0])};
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0)   return {s, 31'd0};
      return {s, e[7:0], m[22:0]};
   endfunction

endpackage

// File: rtl/gs_residual_if.sv
// Result/done bundle between the projection unit (master) and the residual unit (slave).
interface gs_residual_if;
   import gs_residual_pkg::*;

   logic [VEC_W-1:0] B;
   logic [VEC_W-1:0] P;
   logic             proj_valid;
   logic             busy;
   logic [VEC_W-1:0] U;
   logic [FP_W-1:0]  norm2;
   logic             degenerate;
   logic             done;

   modport slave  (input  B, P, proj_valid, output busy, U, norm2, degenerate, done);
   modport master (output B, P, proj_valid, input  busy, U, norm2, degenerate, done);
endinterface

// File: rtl/gs_residual_sub.sv
// One float adder lane; negate flips operand b's sign so the same adder serves a-b and a+b.
module fp_sub
   import gs_residual_pkg::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   input  logic            negate,
   output logic [FP_W-1:0] y
);
   logic [FP_W-1:0] b_eff;

   assign b_eff = negate ? {~b[SIGN_BIT], b[SIGN_BIT-1:0]} : b;
   assign y     = fp_add(a, b_eff);
endmodule

// File: rtl/gs_residual.sv
// Gram-Schmidt residual: U = B - P lane-wise and norm2 = sum of U squared, one job per 5 cycles.
module gs_residual
   import gs_residual_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   gs_residual_if.slave bus
);
   state_t          state_reg, state_next;
   logic            load_in, load_u, load_sq, load_sums, load_out;

   logic [FP_W-1:0] b_reg    [NUM_LANES];
   logic [FP_W-1:0] negp_reg [NUM_LANES];
   logic [FP_W-1:0] u_reg    [NUM_LANES];
   logic [FP_W-1:0] sq_reg   [NUM_LANES];
   logic [FP_W-1:0] s01_reg, s23_reg;
   logic [VEC_W-1:0] u_out_reg;
   logic [FP_W-1:0] norm2_reg;
   logic            degenerate_reg;
   logic            done_reg;

   logic [FP_W-1:0] add_a [NUM_LANES];
   logic [FP_W-1:0] add_b [NUM_LANES];
   logic [FP_W-1:0] add_y [NUM_LANES];
   logic [FP_W-1:0] mul_y [NUM_LANES];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = IDLE;
      load_in    = 1'b0;
      load_u     = 1'b0;
      load_sq    = 1'b0;
      load_sums  = 1'b0;
      load_out   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.proj_valid) begin
               load_in    = 1'b1;
               state_next = SUB;
            end
         end
         SUB: begin
            load_u     = 1'b1;
            state_next = SQR;
         end
         SQR: begin
            load_sq    = 1'b1;
            state_next = ADD1;
         end
         ADD1: begin
            load_sums  = 1'b1;
            state_next = ADD2;
         end
         ADD2: begin
            load_out   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The four lane adders are reused for the reduction tree once the residual is formed.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         add_a[i] = b_reg[i];
         add_b[i] = negp_reg[i];
      end
      if (state_reg == ADD1) begin
         add_a[0] = sq_reg[0];
         add_b[0] = sq_reg[1];
         add_a[1] = sq_reg[2];
         add_b[1] = sq_reg[3];
      end else if (state_reg == ADD2) begin
         add_a[0] = s01_reg;
         add_b[0] = s23_reg;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         fp_sub u_add (
            .a      (add_a[gi]),
            .b      (add_b[gi]),
            .negate (1'b0),
            .y      (add_y[gi])
         );
         assign mul_y[gi] = fp_mul(u_reg[gi], u_reg[gi]);
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            b_reg[i]    <= '0;
            negp_reg[i] <= '0;
            u_reg[i]    <= '0;
            sq_reg[i]   <= '0;
         end
         s01_reg        <= '0;
         s23_reg        <= '0;
         u_out_reg      <= '0;
         norm2_reg      <= '0;
         degenerate_reg <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (load_in) begin
               b_reg[i]    <= bus.B[LANE_HI[i] -: FP_W];
               negp_reg[i] <= {~bus.P[LANE_HI[i]], bus.P[LANE_HI[i]-1 -: FP_W-1]};
            end
            if (load_u)   u_reg[i]  <= add_y[i];
            if (load_sq)  sq_reg[i] <= mul_y[i];
            if (load_out) u_out_reg[LANE_LO[i] +: FP_W] <= u_reg[i];
         end
         if (load_sums) begin
            s01_reg <= add_y[0];
            s23_reg <= add_y[1];
         end
         if (load_out) begin
            norm2_reg      <= add_y[0];
            degenerate_reg <= (add_y[0][EXP_HI:EXP_LO] == '0);
         end
         done_reg <= load_out;
      end
   end

   assign bus.busy       = (state_reg != IDLE);
   assign bus.U          = u_out_reg;
   assign bus.norm2      = norm2_reg;
   assign bus.degenerate = degenerate_reg;
   assign bus.done       = done_reg;
endmodule

// File: tb/tb_gs_residual.sv
// Self-checking bench for gs_residual; expected results come from real-valued arithmetic
// rounded to binary32 after every operation.
module tb_gs_residual;
   import gs_residual_pkg::*;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   gs_residual_if bus();

   gs_residual dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [127:0] NOM_B = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
   localparam logic [127:0] NOM_P = {4{32'h3F000000}};
   localparam logic [127:0] NOM_U = {32'h3F000000, 32'h3FC00000, 32'h40200000, 32'h40600000};

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'd0) return 0.0;
      d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [24:0] k;
      int          e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      k = {2'b01, d[51:29]} + {24'd0, d[28] & ((|d[27:0]) | d[29])};
      if (k[24]) begin
         k = k >> 1;
         e = e + 1;
      end
      return {d[63], e[7:0], k[22:0]};
   endfunction

   task automatic model(input logic [127:0] b, input logic [127:0] p,
                        output logic [127:0] u, output logic [31:0] n2, output logic deg);
      logic [31:0] sq [4];
      logic [31:0] ui;
      logic [31:0] s01;
      logic [31:0] s23;
      for (int i = 0; i < 4; i++) begin
         ui    = r2f(f2r(b[(3-i)*32 +: 32]) - f2r(p[(3-i)*32 +: 32]));
         u[(3-i)*32 +: 32] = ui;
         sq[i] = r2f(f2r(ui) * f2r(ui));
      end
      s01 = r2f(f2r(sq[0]) + f2r(sq[1]));
      s23 = r2f(f2r(sq[2]) + f2r(sq[3]));
      n2  = r2f(f2r(s01) + f2r(s23));
      deg = (n2[30:23] == 8'd0);
   endtask

   function automatic logic [31:0] rnd_f();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
   endfunction

   // Random B/P pair; some lanes cancel exactly or differ only in sign.
   task automatic rnd_pair(output logic [127:0] b, output logic [127:0] p);
      logic [31:0] bl;
      int          sel;
      for (int i = 0; i < 4; i++) begin
         bl  = rnd_f();
         sel = $urandom_range(0, 7);
         b[i*32 +: 32] = bl;
         if (sel == 0)      p[i*32 +: 32] = bl;
         else if (sel == 1) p[i*32 +: 32] = {~bl[31], bl[30:0]};
         else               p[i*32 +: 32] = rnd_f();
      end
   endtask

   // Issues one pulse and waits (bounded) for done; lat counts edges after acceptance.
   task automatic run_job(input logic [127:0] b, input logic [127:0] p,
                          output int lat, output logic seen, output logic busy1);
      @(negedge clk);
      bus.B          = b;
      bus.P          = p;
      bus.proj_valid = 1'b1;
      @(negedge clk);
      bus.proj_valid = 1'b0;
      busy1 = bus.busy;
      lat   = 1;
      while (!bus.done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      seen = bus.done;
      lat  = lat - 1;
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      bus.B          = '0;
      bus.P          = '0;
      bus.proj_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.U !== 128'd0) begin errors++; $display("FAIL reset_U: got %h want 0", bus.U); end
      checks++; if (bus.norm2 !== 32'd0) begin errors++; $display("FAIL reset_norm2: got %h want 0", bus.norm2); end
      checks++; if (bus.degenerate !== 1'b0) begin errors++; $display("FAIL reset_degenerate: got %b want 0", bus.degenerate); end
      reset = 1'b0;
   endtask

   task automatic test_nominal();
      int   lat;
      logic seen;
      logic busy1;
      run_job(NOM_B, NOM_P, lat, seen, busy1);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL nominal_done: got %b want 1 (timeout)", seen); end
      checks++; if (lat != 4) begin errors++; $display("FAIL nominal_latency: got %0d want 4", lat); end
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL nominal_busy: got %b want 1", busy1); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_at_done: got %b want 0", bus.busy); end
      checks++; if (bus.U !== NOM_U) begin errors++; $display("FAIL nominal_U: got %h want %h", bus.U, NOM_U); end
      checks++; if (bus.norm2 !== 32'h41A80000) begin errors++; $display("FAIL nominal_norm2: got %h want 41a80000", bus.norm2); end
      checks++; if (bus.degenerate !== 1'b0) begin errors++; $display("FAIL nominal_degenerate: got %b want 0", bus.degenerate); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL nominal_done_width: got %b want 0", bus.done); end
      checks++; if (bus.U !== NOM_U) begin errors++; $display("FAIL nominal_U_hold: got %h want %h", bus.U, NOM_U); end
   endtask

   task automatic test_dependent();
      int   lat;
      logic seen;
      logic busy1;
      run_job(NOM_B, NOM_B, lat, seen, busy1);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL dependent_done: got %b want 1 (timeout)", seen); end
      checks++; if (bus.U !== 128'd0) begin errors++; $display("FAIL dependent_U: got %h want 0", bus.U); end
      checks++; if (bus.norm2 !== 32'd0) begin errors++; $display("FAIL dependent_norm2: got %h want 0", bus.norm2); end
      checks++; if (bus.degenerate !== 1'b1) begin errors++; $display("FAIL dependent_degenerate: got %b want 1", bus.degenerate); end
   endtask

   task automatic test_signs();
      int   lat;
      logic seen;
      logic busy1;
      logic [127:0] p;
      logic [127:0] exp_u;
      p     = {32'h3F800000, 32'hC0000000, 32'h0, 32'h0};
      exp_u = {32'hBF800000, 32'h40000000, 32'h0, 32'h0};
      run_job(128'd0, p, lat, seen, busy1);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL signs_done: got %b want 1 (timeout)", seen); end
      checks++; if (bus.U !== exp_u) begin errors++; $display("FAIL signs_U: got %h want %h", bus.U, exp_u); end
      checks++; if (bus.norm2 !== 32'h40A00000) begin errors++; $display("FAIL signs_norm2: got %h want 40a00000", bus.norm2); end
      checks++; if (bus.degenerate !== 1'b0) begin errors++; $display("FAIL signs_degenerate: got %b want 0", bus.degenerate); end
   endtask

   // Pulses at t=0 (accepted), t=2 (dropped while busy), t=5 (coincident with done, accepted).
   task automatic test_back_to_back();
      logic [127:0] a, pa, c, pc, d, pd;
      logic [127:0] ua, ud;
      logic [31:0]  na, nd;
      logic         ga, gd;
      rnd_pair(a, pa);
      rnd_pair(c, pc);
      rnd_pair(d, pd);
      model(a, pa, ua, na, ga);
      model(d, pd, ud, nd, gd);
      for (int t = 0; t <= 12; t++) begin
         @(negedge clk);
         if (t > 0) begin
            checks++;
            if (bus.done !== (t == 5 || t == 10)) begin
               errors++; $display("FAIL b2b_done t=%0d: got %b want %b", t, bus.done, (t == 5 || t == 10));
            end
         end
         if (t == 5 || t == 9) begin
            checks++; if (bus.U !== ua) begin errors++; $display("FAIL b2b_first_U t=%0d: got %h want %h", t, bus.U, ua); end
            checks++; if (bus.norm2 !== na) begin errors++; $display("FAIL b2b_first_norm2 t=%0d: got %h want %h", t, bus.norm2, na); end
         end
         if (t == 10) begin
            checks++; if (bus.U !== ud) begin errors++; $display("FAIL b2b_third_U: got %h want %h", bus.U, ud); end
            checks++; if (bus.norm2 !== nd) begin errors++; $display("FAIL b2b_third_norm2: got %h want %h", bus.norm2, nd); end
            checks++; if (bus.degenerate !== gd) begin errors++; $display("FAIL b2b_third_degenerate: got %b want %b", bus.degenerate, gd); end
         end
         bus.proj_valid = (t == 0 || t == 2 || t == 5);
         if (t == 0) begin bus.B = a; bus.P = pa; end
         if (t == 2) begin bus.B = c; bus.P = pc; end
         if (t == 5) begin bus.B = d; bus.P = pd; end
      end
      bus.proj_valid = 1'b0;
   endtask

   // proj_valid held for 7 cycles: accepted at t=0 and again in the done cycle t=5.
   task automatic test_held_valid();
      logic [127:0] b, p, u;
      logic [31:0]  n2;
      logic         g;
      rnd_pair(b, p);
      model(b, p, u, n2, g);
      for (int t = 0; t <= 12; t++) begin
         @(negedge clk);
         if (t > 0) begin
            checks++;
            if (bus.done !== (t == 5 || t == 10)) begin
               errors++; $display("FAIL held_done t=%0d: got %b want %b", t, bus.done, (t == 5 || t == 10));
            end
         end
         if (t == 10) begin
            checks++; if (bus.U !== u) begin errors++; $display("FAIL held_U: got %h want %h", bus.U, u); end
            checks++; if (bus.norm2 !== n2) begin errors++; $display("FAIL held_norm2: got %h want %h", bus.norm2, n2); end
         end
         bus.B          = b;
         bus.P          = p;
         bus.proj_valid = (t <= 6);
      end
      bus.proj_valid = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      int   lat;
      logic seen;
      logic busy1;
      int   stray;
      @(negedge clk);
      bus.B          = NOM_B;
      bus.P          = NOM_P;
      bus.proj_valid = 1'b1;
      @(negedge clk);
      bus.proj_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
      reset = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
      checks++; if (bus.U !== 128'd0) begin errors++; $display("FAIL midrst_U: got %h want 0", bus.U); end
      checks++; if (bus.norm2 !== 32'd0) begin errors++; $display("FAIL midrst_norm2: got %h want 0", bus.norm2); end
      checks++; if (bus.degenerate !== 1'b0) begin errors++; $display("FAIL midrst_degenerate: got %b want 0", bus.degenerate); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      stray = 0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         if (bus.done === 1'b1) stray++;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL midrst_stray_done: got %0d want 0", stray); end
      run_job(NOM_B, NOM_P, lat, seen, busy1);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL midrst_after_done: got %b want 1 (timeout)", seen); end
      checks++; if (bus.U !== NOM_U) begin errors++; $display("FAIL midrst_after_U: got %h want %h", bus.U, NOM_U); end
      checks++; if (bus.norm2 !== 32'h41A80000) begin errors++; $display("FAIL midrst_after_norm2: got %h want 41a80000", bus.norm2); end
   endtask

   task automatic test_random();
      logic [127:0] b, p, u;
      logic [31:0]  n2;
      logic         g;
      int           lat;
      logic         seen;
      logic         busy1;
      for (int n = 0; n < 40; n++) begin
         rnd_pair(b, p);
         model(b, p, u, n2, g);
         run_job(b, p, lat, seen, busy1);
         checks++; if (seen !== 1'b1 || lat != 4) begin errors++; $display("FAIL rand_latency #%0d: got done=%b lat=%0d want done=1 lat=4", n, seen, lat); end
         checks++; if (bus.U !== u) begin errors++; $display("FAIL rand_U #%0d: got %h want %h (B=%h P=%h)", n, bus.U, u, b, p); end
         checks++; if (bus.norm2 !== n2) begin errors++; $display("FAIL rand_norm2 #%0d: got %h want %h", n, bus.norm2, n2); end
         checks++; if (bus.degenerate !== g) begin errors++; $display("FAIL rand_degenerate #%0d: got %b want %b", n, bus.degenerate, g); end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_dependent();
      test_signs();
      test_back_to_back();
      test_held_valid();
      test_reset_mid_op();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
